// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: fetch-stage constants and state encoding shared with the control unit
package instr_fetch_unit_pkg;
  localparam int WORD = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;
  localparam logic [WORD-1:0] PC_INC = 16'd1;
  typedef enum logic [1:0] {
    REQ    = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_e;
endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instruction words and offers them to the control unit via valid/ready
module instr_fetch_unit #(
  parameter int WORD = 16,
  parameter logic [WORD-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_read_req,
  output logic [WORD-1:0] mem_addr,
  input  logic [WORD-1:0] mem_data,
  input  logic            mem_input_ready,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [WORD-1:0] inst,
  output logic [3:0]      opcode,
  output logic [5:0]      func,
  output logic [WORD-1:0] inst_pc,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted,
  output logic [WORD-1:0] num_inst
);
  import instr_fetch_unit_pkg::*;
  state_e state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d, inst_q, inst_d, inst_pc_q, inst_pc_d, num_q, num_d;
  logic accept;
  assign accept = (state_q == HOLD) && inst_ready;
  // next-state: halt beats redirect, redirect discards any same-cycle memory response
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    inst_d = inst_q;
    inst_pc_d = inst_pc_q;
    num_d = accept ? num_q + WORD'(1) : num_q;
    if (state_q != HALTED) begin
      if (halt) state_d = HALTED;
      else if (redirect) begin
        pc_d = redirect_pc;
        state_d = REQ;
      end else if (state_q == REQ && mem_input_ready) begin
        inst_d = mem_data;
        inst_pc_d = pc_q;
        pc_d = pc_q + WORD'(PC_INC);
        state_d = HOLD;
      end else if (accept) state_d = REQ;
    end
  end
  // state, pc, latched instruction and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= REQ;
      pc_q <= PC_RESET;
      inst_q <= '0;
      inst_pc_q <= '0;
      num_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      inst_pc_q <= inst_pc_d;
      num_q <= num_d;
    end
  end
  assign mem_read_req = state_q == REQ;
  assign mem_addr = pc_q;
  assign inst_valid = state_q == HOLD;
  assign halted = state_q == HALTED;
  assign inst = inst_q;
  assign opcode = inst_q[OPCODE_MSB:OPCODE_LSB];
  assign func = inst_q[FUNC_MSB:FUNC_LSB];
  assign inst_pc = inst_pc_q;
  assign num_inst = num_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plan plus randomized traffic checked against a transaction-level model
module tb_instr_fetch_unit;
  logic clk = 0, reset = 1;
  logic mem_read_req, mem_input_ready = 0, inst_valid, inst_ready = 0;
  logic redirect = 0, halt = 0, halted;
  logic [15:0] mem_addr, mem_data = 0, inst, inst_pc, redirect_pc = 0, num_inst;
  logic [3:0] opcode;
  logic [5:0] func;
  logic [15:0] m_pc, m_inst, m_inst_pc, m_cnt;
  bit m_valid, m_halted, rand_lat;
  int wait_cnt, lat, checks, errors;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .mem_read_req(mem_read_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_input_ready(mem_input_ready), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .opcode(opcode), .func(func), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .halted(halted),
    .num_inst(num_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a == 16'h0 ? 16'hF000 : a == 16'h1 ? 16'h4123 : (a * 16'h9E37) ^ 16'h1234;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("req", 16'(mem_read_req), 16'(!m_halted && !m_valid));
    check("addr", mem_addr, m_pc);
    check("valid", 16'(inst_valid), 16'(m_valid));
    check("halted", 16'(halted), 16'(m_halted));
    check("inst", inst, m_inst);
    check("inst_pc", inst_pc, m_inst_pc);
    check("opcode", 16'(opcode), 16'(m_inst[15:12]));
    check("func", 16'(func), 16'(m_inst[5:0]));
    check("num_inst", num_inst, m_cnt);
  endtask

  task automatic model_reset();
    m_pc = 0; m_inst = 0; m_inst_pc = 0; m_cnt = 0; m_valid = 0; m_halted = 0; wait_cnt = 0;
  endtask

  task automatic cyc(input bit rdy, input bit rd, input logic [15:0] rpc, input bit hl);
    bit req, acc;
    @(negedge clk);
    inst_ready = rdy; redirect = rd; redirect_pc = rpc; halt = hl;
    req = mem_read_req;
    mem_input_ready = req && wait_cnt >= lat;
    mem_data = mem_input_ready ? memf(mem_addr) : 16'h0;
    #1 check_all();
    @(posedge clk);
    acc = m_valid && rdy;
    if (acc) m_cnt++;
    if (!m_halted) begin
      if (hl) begin m_halted = 1; m_valid = 0; end
      else if (rd) begin m_pc = rpc; m_valid = 0; end
      else if (!m_valid && mem_input_ready) begin
        m_inst = mem_data; m_inst_pc = m_pc; m_pc++; m_valid = 1;
      end else if (acc) m_valid = 0;
    end
    if (!req || mem_input_ready || rd || hl) begin
      wait_cnt = 0;
      if (rand_lat) lat = $urandom_range(0, 3);
    end else wait_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    inst_ready = 0; redirect = 0; halt = 0; mem_input_ready = 0;
    #2 reset = 1;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    rand_lat = 0; lat = 0;
    do_reset();
    cyc(1, 0, 0, 0);
    #1 check("t1_valid", 16'(inst_valid), 16'd1);
    check("t1_opcode", 16'(opcode), 16'hF);
    check("t1_func", 16'(func), 16'h0);
    cyc(1, 0, 0, 0);
    #1 check("t1_num", num_inst, 16'd1);
    check("t1_addr", mem_addr, 16'd1);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    #1 check("t3_inst", inst, 16'h4123);
    check("t3_pc", inst_pc, 16'd1);
    check("t3_req", 16'(mem_read_req), 16'd0);
    check("t3_num", num_inst, 16'd1);
    lat = 2;
    cyc(1, 0, 0, 0);
    #1 check("t3_num_acc", num_inst, 16'd2);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 0);
      #1 check("t2_req", 16'(mem_read_req), 16'd1);
      check("t2_addr", mem_addr, 16'd2);
    end
    cyc(1, 0, 0, 0);
    #1 check("t2_valid", 16'(inst_valid), 16'd1);
    lat = 0;
    cyc(1, 0, 0, 0);
    cyc(1, 1, 16'h0040, 0);
    #1 check("t4_addr", mem_addr, 16'h0040);
    check("t4_valid", 16'(inst_valid), 16'd0);
    cyc(1, 0, 0, 0);
    #1 check("t4_inst_pc", inst_pc, 16'h0040);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 16'hFFFF, 0);
    cyc(1, 0, 0, 0);
    #1 check("t5_inst_pc", inst_pc, 16'hFFFF);
    cyc(1, 0, 0, 0);
    #1 check("t5_wrap", mem_addr, 16'h0000);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 16'h1234, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
      #1 check("t6_halted", 16'(halted), 16'd1);
      check("t6_pc", mem_addr, 16'd1);
      check("t6_req", 16'(mem_read_req), 16'd0);
    end
    do_reset();
    #1 check("t6_rst_addr", mem_addr, 16'h0000);
    check("t6_rst_halted", 16'(halted), 16'd0);
    rand_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      if ((m_halted && $urandom_range(0, 19) == 0) || $urandom_range(0, 299) == 0) do_reset();
      else cyc($urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 3) == 0 ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom),
               $urandom_range(0, 99) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
